// File: rtl/exception_pkg.sv
// Shared definitions for the MM-stage exception controller: sequencer states,
// CP0 cause codes and exception vector offsets.
package exception_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        WAIT_RDY = 2'd2
    } state_e;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_CPU  = 5'h0b;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [31:0] VEC_REFILL    = 32'h0000_0000;
    localparam logic [31:0] VEC_GENERAL   = 32'h0000_0180;
    localparam logic [31:0] VEC_INTERRUPT = 32'h0000_0200;
    localparam logic [31:0] BOOT_BASE     = 32'hBFC0_0200;

endpackage

// File: rtl/int_line_sync.sv
// One interrupt line: 2-flop synchroniser followed by either a level pass-through
// or a sticky rising-edge latch that software clears.
module int_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic edge_mode_i,
    input  logic clear_i,
    output logic pending_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic sticky_q;
    logic sticky_d;

    // A fresh edge outranks a clear arriving in the same cycle so no edge is lost.
    assign sticky_d = (sync2_q & ~prev_q) | (sticky_q & ~clear_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            sticky_q <= sticky_d;
        end
    end

    assign pending_o = edge_mode_i ? sticky_q : sync2_q;

endmodule

// File: rtl/exception_ctrl.sv
// Registered exception/interrupt controller for the MM stage. Define
// EXCEPTION_CTRL_VECTORED_INT_EN to spread interrupts across per-line vectors.
module exception_ctrl
    import exception_pkg::*;
#(
    parameter int NUM_INT     = 8,
    parameter int VEC_SPACING = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_INT-1:0] int_raw,
    input  logic [NUM_INT-1:0] int_edge_mode,
    input  logic [NUM_INT-1:0] int_clear,
    input  logic [NUM_INT-1:0] int_mask,
    input  logic               allow_int,
    input  logic               is_real_inst,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic               exc_badv_we,
    input  logic [31:0]        exc_bad_vaddr,
    input  logic               exc_asid_we,
    input  logic [7:0]         exc_asid,
    input  logic               exc_tlb_refill,
    input  logic               eret,
    input  logic [31:0]        pc_value,
    input  logic               in_delayslot,
    input  logic [31:0]        epc_in,
    input  logic [19:0]        ebase_in,
    input  logic               boot_exp_vec,
    input  logic               special_int_vec,
    input  logic               exl_in,
    input  logic               redirect_ready,
    output logic               flush,
    output logic               cp0_wr_exp,
    output logic               cp0_clean_exl,
    output logic [4:0]         exp_code,
    output logic [31:0]        exp_epc,
    output logic [31:0]        exp_bad_vaddr,
    output logic               cp0_badv_we,
    output logic [7:0]         exp_asid,
    output logic               cp0_exp_asid_we,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [NUM_INT-1:0] int_pending,
    output logic               busy
);

    localparam int VEC_SHIFT = $clog2(VEC_SPACING);

    logic [NUM_INT-1:0] maskedInt;
    logic               takeInt;
    logic               takeExc;
    logic               anyEvent;
    logic [4:0]         intIdx;
    logic [31:0]        baseAddr;
    logic [31:0]        vecOffset;
    logic [31:0]        targetPc_d;
    logic [31:0]        epc_d;

    state_e      state_q;
    logic        flush_q;
    logic        wrExp_q;
    logic        cleanExl_q;
    logic        badvWe_q;
    logic        asidWe_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;
    logic [31:0] badv_q;
    logic [7:0]  asid_q;
    logic        redirValid_q;
    logic [31:0] redirPc_q;

    for (genvar g = 0; g < NUM_INT; g++) begin : g_line
        int_line_sync u_sync (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw_i       (int_raw[g]),
            .edge_mode_i (int_edge_mode[g]),
            .clear_i     (int_clear[g]),
            .pending_o   (int_pending[g])
        );
    end

    assign maskedInt = int_pending & int_mask;
    assign takeInt   = allow_int && is_real_inst && (|maskedInt);
    assign takeExc   = !takeInt && exc_valid;
    assign anyEvent  = takeInt || exc_valid || eret;

`ifdef EXCEPTION_CTRL_VECTORED_INT_EN
    // Later iterations overwrite earlier ones, so the highest set line wins.
    always_comb begin
        intIdx = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (maskedInt[i]) intIdx = 5'(i);
        end
    end
`else
    assign intIdx = '0;
`endif

    assign vecOffset = {27'd0, intIdx} << VEC_SHIFT;
    assign baseAddr  = boot_exp_vec ? BOOT_BASE : {ebase_in, 12'h000};
    assign epc_d     = in_delayslot ? (pc_value - 32'd4) : pc_value;

    always_comb begin
        if (takeExc && exc_tlb_refill && !exl_in)
            targetPc_d = baseAddr + VEC_REFILL;
        else if (takeInt && special_int_vec)
            targetPc_d = baseAddr + VEC_INTERRUPT + vecOffset;
        else if (!takeInt && !exc_valid && eret)
            targetPc_d = epc_in;
        else
            targetPc_d = baseAddr + VEC_GENERAL;
    end

    // Sequencer: capture one event in IDLE, pulse CP0 writes for one cycle,
    // then hold the redirect until fetch takes it. New events are ignored meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flush_q      <= 1'b0;
            wrExp_q      <= 1'b0;
            cleanExl_q   <= 1'b0;
            badvWe_q     <= 1'b0;
            asidWe_q     <= 1'b0;
            code_q       <= '0;
            epc_q        <= '0;
            badv_q       <= '0;
            asid_q       <= '0;
            redirValid_q <= 1'b0;
            redirPc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyEvent) begin
                        state_q      <= FLUSH;
                        flush_q      <= 1'b1;
                        redirValid_q <= 1'b1;
                        redirPc_q    <= targetPc_d;
                        epc_q        <= epc_d;
                        wrExp_q      <= takeInt || exc_valid;
                        cleanExl_q   <= !takeInt && !exc_valid;
                        code_q       <= takeExc ? exc_code : EXC_INT;
                        badvWe_q     <= takeExc && exc_badv_we;
                        asidWe_q     <= takeExc && exc_asid_we;
                        badv_q       <= takeExc ? exc_bad_vaddr : 32'd0;
                        asid_q       <= takeExc ? exc_asid : 8'd0;
                    end
                end
                FLUSH: begin
                    flush_q    <= 1'b0;
                    wrExp_q    <= 1'b0;
                    cleanExl_q <= 1'b0;
                    badvWe_q   <= 1'b0;
                    asidWe_q   <= 1'b0;
                    if (redirect_ready) begin
                        state_q      <= IDLE;
                        redirValid_q <= 1'b0;
                        redirPc_q    <= '0;
                        code_q       <= '0;
                        epc_q        <= '0;
                        badv_q       <= '0;
                        asid_q       <= '0;
                    end else begin
                        state_q <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (redirect_ready) begin
                        state_q      <= IDLE;
                        redirValid_q <= 1'b0;
                        redirPc_q    <= '0;
                        code_q       <= '0;
                        epc_q        <= '0;
                        badv_q       <= '0;
                        asid_q       <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flush           = flush_q;
    assign cp0_wr_exp      = wrExp_q;
    assign cp0_clean_exl   = cleanExl_q;
    assign exp_code        = code_q;
    assign exp_epc         = epc_q;
    assign exp_bad_vaddr   = badv_q;
    assign cp0_badv_we     = badvWe_q;
    assign exp_asid        = asid_q;
    assign cp0_exp_asid_we = asidWe_q;
    assign redirect_valid  = redirValid_q;
    assign redirect_pc     = redirPc_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: directed events push expected CP0/redirect
// results, and a negedge monitor pops and compares them on every flush pulse.
module tb_exception_ctrl;

    localparam int NI = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] int_raw, int_edge_mode, int_clear, int_mask;
    logic          allow_int, is_real_inst, exc_valid;
    logic [4:0]    exc_code;
    logic          exc_badv_we, exc_asid_we, exc_tlb_refill, eret;
    logic [31:0]   exc_bad_vaddr, pc_value, epc_in;
    logic [7:0]    exc_asid;
    logic          in_delayslot, boot_exp_vec, special_int_vec, exl_in, redirect_ready;
    logic [19:0]   ebase_in;
    logic          flush, cp0_wr_exp, cp0_clean_exl, cp0_badv_we, cp0_exp_asid_we;
    logic          redirect_valid, busy;
    logic [4:0]    exp_code;
    logic [31:0]   exp_epc, exp_bad_vaddr, redirect_pc;
    logic [7:0]    exp_asid;
    logic [NI-1:0] int_pending;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        wrExp;
        logic        clean;
        logic        badvWe;
        logic [31:0] badv;
        logic        asidWe;
        logic [7:0]  asid;
    } exp_t;

    exp_t        sbQ[$];
    int          errors = 0;
    int          checks = 0;
    logic        prevFlush = 1'b0;
    logic [31:0] lastPc = '0;

    exception_ctrl #(.NUM_INT(NI), .VEC_SPACING(32)) dut (
        .clk(clk), .rst_n(rst_n), .int_raw(int_raw), .int_edge_mode(int_edge_mode),
        .int_clear(int_clear), .int_mask(int_mask), .allow_int(allow_int),
        .is_real_inst(is_real_inst), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_badv_we(exc_badv_we), .exc_bad_vaddr(exc_bad_vaddr), .exc_asid_we(exc_asid_we),
        .exc_asid(exc_asid), .exc_tlb_refill(exc_tlb_refill), .eret(eret),
        .pc_value(pc_value), .in_delayslot(in_delayslot), .epc_in(epc_in),
        .ebase_in(ebase_in), .boot_exp_vec(boot_exp_vec), .special_int_vec(special_int_vec),
        .exl_in(exl_in), .redirect_ready(redirect_ready), .flush(flush),
        .cp0_wr_exp(cp0_wr_exp), .cp0_clean_exl(cp0_clean_exl), .exp_code(exp_code),
        .exp_epc(exp_epc), .exp_bad_vaddr(exp_bad_vaddr), .cp0_badv_we(cp0_badv_we),
        .exp_asid(exp_asid), .cp0_exp_asid_we(cp0_exp_asid_we),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .int_pending(int_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic [4:0] code, input logic [31:0] epc, input logic [31:0] pc,
                           input logic wrExp, input logic clean, input logic badvWe,
                           input logic [31:0] badv, input logic asidWe, input logic [7:0] asid);
        exp_t e;
        e.code = code; e.epc = epc; e.pc = pc; e.wrExp = wrExp; e.clean = clean;
        e.badvWe = badvWe; e.badv = badv; e.asidWe = asidWe; e.asid = asid;
        sbQ.push_back(e);
    endtask

    // One-cycle pulse of the synchronous exception and/or eret inputs.
    task automatic applyStimulus(input logic doExc, input logic doEret);
        @(negedge clk);
        exc_valid = doExc;
        eret      = doEret;
        @(negedge clk);
        exc_valid = 1'b0;
        eret      = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: still busy after 20 cycles, expected idle", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every flush pops one expected event; outside flush the pulses
    // must be quiet and a held redirect must keep its PC.
    always @(negedge clk) begin
        exp_t e;
        if (flush) begin
            checkOutput("flush_single_cycle", {31'd0, prevFlush}, 32'd0);
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_flush: got flush with pc %h, expected none", redirect_pc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("redirect_valid", {31'd0, redirect_valid}, 32'd1);
                checkOutput("redirect_pc", redirect_pc, e.pc);
                checkOutput("cp0_wr_exp", {31'd0, cp0_wr_exp}, {31'd0, e.wrExp});
                checkOutput("cp0_clean_exl", {31'd0, cp0_clean_exl}, {31'd0, e.clean});
                checkOutput("cp0_badv_we", {31'd0, cp0_badv_we}, {31'd0, e.badvWe});
                checkOutput("cp0_exp_asid_we", {31'd0, cp0_exp_asid_we}, {31'd0, e.asidWe});
                if (e.wrExp) begin
                    checkOutput("exp_code", {27'd0, exp_code}, {27'd0, e.code});
                    checkOutput("exp_epc", exp_epc, e.epc);
                end
                if (e.badvWe) checkOutput("exp_bad_vaddr", exp_bad_vaddr, e.badv);
                if (e.asidWe) checkOutput("exp_asid", {24'd0, exp_asid}, {24'd0, e.asid});
                lastPc = e.pc;
            end
        end else begin
            checkOutput("pulses_quiet",
                        {28'd0, cp0_wr_exp, cp0_clean_exl, cp0_badv_we, cp0_exp_asid_we}, 32'd0);
            if (redirect_valid) checkOutput("redirect_pc_stable", redirect_pc, lastPc);
        end
        prevFlush = flush;
    end

    initial begin
        int cnt;
        logic [31:0] vecPc;
        rst_n = 1'b0;
        int_raw = '0; int_edge_mode = '0; int_clear = '0; int_mask = '0;
        allow_int = 1'b0; is_real_inst = 1'b1; exc_valid = 1'b0; exc_code = '0;
        exc_badv_we = 1'b0; exc_bad_vaddr = '0; exc_asid_we = 1'b0; exc_asid = '0;
        exc_tlb_refill = 1'b0; eret = 1'b0; pc_value = '0; in_delayslot = 1'b0;
        epc_in = '0; ebase_in = 20'h80000; boot_exp_vec = 1'b0; special_int_vec = 1'b0;
        exl_in = 1'b0; redirect_ready = 1'b1;

        waitCycles(3);
        checkOutput("reset_ctrl", {27'd0, flush, cp0_wr_exp, cp0_clean_exl, redirect_valid, busy}, 32'd0);
        checkOutput("reset_pending", {24'd0, int_pending}, 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
        rst_n = 1'b1;
        waitCycles(2);

        // Level line 0: visible after exactly two clocks, masked so never taken.
        int_raw[0] = 1'b1;
        waitCycles(1);
        checkOutput("level_latency_1", {31'd0, int_pending[0]}, 32'd0);
        waitCycles(1);
        checkOutput("level_latency_2", {31'd0, int_pending[0]}, 32'd1);
        int_raw[0] = 1'b0;
        waitCycles(3);

        // Edge line 3 with special vector; eligibility after three clocks.
        int_edge_mode = 8'h08; int_mask = 8'h08; special_int_vec = 1'b1;
        pc_value = 32'h8000_0100;
`ifdef EXCEPTION_CTRL_VECTORED_INT_EN
        vecPc = 32'h8000_0260;
`else
        vecPc = 32'h8000_0200;
`endif
        int_raw[3] = 1'b1;
        waitCycles(2);
        checkOutput("edge_latency_2", {31'd0, int_pending[3]}, 32'd0);
        waitCycles(1);
        checkOutput("edge_latency_3", {31'd0, int_pending[3]}, 32'd1);
        pushExp(5'h00, 32'h8000_0100, vecPc, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0);
        allow_int = 1'b1; int_clear = 8'h08;
        waitCycles(1);
        allow_int = 1'b0; int_clear = 8'h00;
        checkOutput("edge_cleared", {31'd0, int_pending[3]}, 32'd0);
        waitIdle("int_edge");
        special_int_vec = 1'b0;

        // A clear landing in the same cycle as a new edge must not drop it.
        int_raw[3] = 1'b0; waitCycles(4);
        int_raw[3] = 1'b1; waitCycles(4);
        checkOutput("edge_relatched", {31'd0, int_pending[3]}, 32'd1);
        int_raw[3] = 1'b0; waitCycles(4);
        int_raw[3] = 1'b1; waitCycles(2);
        int_clear = 8'h08; waitCycles(1);
        int_clear = 8'h00;
        checkOutput("set_beats_clear", {31'd0, int_pending[3]}, 32'd1);
        int_raw[3] = 1'b0; int_clear = 8'h08; waitCycles(1);
        int_clear = 8'h00; int_mask = 8'h00; int_edge_mode = 8'h00;
        checkOutput("sw_clear", {24'd0, int_pending}, 32'd0);

        // Overflow in a delay slot.
        exc_code = 5'h0c; pc_value = 32'h8000_1004; in_delayslot = 1'b1;
        pushExp(5'h0c, 32'h8000_1000, 32'h8000_0180, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0);
        waitIdle("exc_ov");
        in_delayslot = 1'b0;

        // TLB refill, first with EXL clear then set.
        exc_code = 5'h02; exc_tlb_refill = 1'b1; exc_badv_we = 1'b1; exc_bad_vaddr = 32'h0040_1234;
        exc_asid_we = 1'b1; exc_asid = 8'h5a; pc_value = 32'h8000_4000; exl_in = 1'b0;
        pushExp(5'h02, 32'h8000_4000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h0040_1234, 1'b1, 8'h5a);
        applyStimulus(1'b1, 1'b0);
        waitIdle("refill_exl0");
        exl_in = 1'b1; exc_asid = 8'h3c;
        pushExp(5'h02, 32'h8000_4000, 32'h8000_0180, 1'b1, 1'b0, 1'b1, 32'h0040_1234, 1'b1, 8'h3c);
        applyStimulus(1'b1, 1'b0);
        waitIdle("refill_exl1");
        exl_in = 1'b0; exc_tlb_refill = 1'b0; exc_badv_we = 1'b0; exc_asid_we = 1'b0;

        // Boot vector base.
        boot_exp_vec = 1'b1; exc_code = 5'h0a; pc_value = 32'hBFC0_0010;
        pushExp(5'h0a, 32'hBFC0_0010, 32'hBFC0_0380, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0);
        waitIdle("boot_vec");
        boot_exp_vec = 1'b0;

        // Interrupt and exception together: interrupt wins.
        int_raw[5] = 1'b1; int_mask = 8'h20; pc_value = 32'h8000_5000; exc_code = 5'h0c;
        waitCycles(3);
        pushExp(5'h00, 32'h8000_5000, 32'h8000_0180, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0);
        allow_int = 1'b1; exc_valid = 1'b1;
        waitCycles(1);
        allow_int = 1'b0; exc_valid = 1'b0;
        int_raw[5] = 1'b0; int_mask = 8'h00;
        waitIdle("int_vs_exc");

        // ERET held off by fetch for four cycles; a second ERET is ignored.
        epc_in = 32'h8000_2000; redirect_ready = 1'b0;
        pushExp(5'h00, 32'd0, 32'h8000_2000, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
        @(negedge clk); eret = 1'b1;
        @(negedge clk); eret = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (!redirect_valid) break;
            cnt++;
            if (cnt == 2) eret = 1'b1;
            if (cnt == 3) eret = 1'b0;
            if (cnt == 5) redirect_ready = 1'b1;
            @(negedge clk);
        end
        redirect_ready = 1'b1;
        checkOutput("eret_hold_cycles", cnt, 32'd5);
        waitCycles(2);
        checkOutput("eret_second_ignored", {31'd0, busy}, 32'd0);

        // Reset in WAIT_RDY drops everything at once.
        int_raw[0] = 1'b1;
        epc_in = 32'h8000_3000; redirect_ready = 1'b0;
        pushExp(5'h00, 32'd0, 32'h8000_3000, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("wait_before_reset", {30'd0, busy, redirect_valid}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", {27'd0, flush, cp0_wr_exp, cp0_clean_exl, redirect_valid, busy}, 32'd0);
        checkOutput("async_reset_pc", redirect_pc, 32'd0);
        checkOutput("async_reset_pending", {24'd0, int_pending}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; redirect_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_pending", {24'd0, int_pending}, 32'd0);
        checkOutput("post_reset_idle", {30'd0, busy, redirect_valid}, 32'd0);
        int_raw[0] = 1'b0;
        waitCycles(3);

        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Registered, parametrised exception and interrupt controller for the MM stage. It is the successor to the combinational exception priority logic. Per-line interrupt synchronisation and edge latching, masking and priority selection cover `NUM_INT` lines, with optional vectored interrupts. A three-state sequencer issues a one-cycle flush and CP0 write, then holds a PC redirect until fetch accepts it.

## Interface
Parameters:
- `NUM_INT`, default 8: number of interrupt lines, 1..32. The highest index has the highest priority.
- `VEC_SPACING`, default 32: byte spacing between vectored interrupt entries. Must be a power of 2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `int_raw` in NUM_INT: raw interrupt lines, asynchronous.
- `int_edge_mode` in NUM_INT: per line, 1 = rising-edge latched, 0 = level.
- `int_clear` in NUM_INT: software clear of latched edge bits.
- `int_mask` in NUM_INT: enable per line.
- `allow_int` in 1: Status.IE && !EXL && !ERL.
- `is_real_inst` in 1: MM slot holds a real instruction.
- `exc_valid` in 1: synchronous exception present in MM.
- `exc_code` in 5: cause code for the synchronous exception.
- `exc_badv_we` in 1, `exc_bad_vaddr` in 32: BadVAddr update.
- `exc_asid_we` in 1, `exc_asid` in 8: EntryHi ASID update.
- `exc_tlb_refill` in 1: TLB miss that uses the refill vector.
- `eret` in 1: ERET in MM.
- `pc_value` in 32, `in_delayslot` in 1: PC and delay-slot flag of the MM instruction.
- `epc_in` in 32, `ebase_in` in 20, `boot_exp_vec` in 1, `special_int_vec` in 1, `exl_in` in 1: CP0 state.
- `redirect_ready` in 1: fetch accepts the redirect.
- `flush` out 1: pipeline flush pulse.
- `cp0_wr_exp` out 1, `cp0_clean_exl` out 1: CP0 write pulses.
- `exp_code` out 5, `exp_epc` out 32, `exp_bad_vaddr` out 32, `cp0_badv_we` out 1, `exp_asid` out 8, `cp0_exp_asid_we` out 1: CP0 write data and enables.
- `redirect_valid` out 1, `redirect_pc` out 32: redirect handshake.
- `int_pending` out NUM_INT: pending lines, before masking, to Cause.IP.
- `busy` out 1: state is not IDLE.

## Operation
- Synchronisation: every `int_raw` bit passes through a 2-flop synchroniser.
  - Level lines: pending = synchronised value.
  - Edge lines: a sticky bit sets on a synchronised 0->1 transition and clears on `int_clear`. If set and clear occur in the same cycle, set wins.
  - Latching continues in every state.
- Eligible interrupt: `allow_int && is_real_inst && |(int_pending & int_mask)`. The line index is the highest set bit of `int_pending & int_mask`.
- IDLE event priority: interrupt, then `exc_valid`, then `eret`. The chosen event is captured into holding registers and the state moves to FLUSH.
- Captured CP0 data per event:
  - Interrupt: code 0x00, no BadVAddr or ASID write.
  - `exc_valid`: `exc_code`, BadVAddr and ASID write enables as given.
  - `eret`: `cp0_clean_exl` instead of `cp0_wr_exp`.
  - `exp_epc` = `in_delayslot ? pc_value-4 : pc_value`.
- Base address: `boot_exp_vec ? 32'hBFC00200 : {ebase_in,12'h000}`.
- Target PC:
  - TLB refill with `!exl_in`: base+0x000.
  - Interrupt with `special_int_vec`: base+0x200.
  - `eret`: `epc_in`.
  - Otherwise: base+0x180.
- States:
  - IDLE: outputs quiet.
  - FLUSH: one cycle. `flush`=1, `cp0_wr_exp` or `cp0_clean_exl` =1, write enables as captured, `redirect_valid`=1.
  - WAIT_RDY: `redirect_valid`=1 held with `redirect_pc` stable until `redirect_ready`.
- Transitions:
  - FLUSH goes to IDLE if `redirect_ready`, else to WAIT_RDY.
  - WAIT_RDY goes to IDLE on `redirect_ready`.
  - In FLUSH and WAIT_RDY, `exc_valid`, `eret` and interrupts are not evaluated. The pipeline is flushed and upstream is invalid.
- Arithmetic: all address sums are modulo 2^32. The vector offset uses index × `VEC_SPACING`, zero-extended.

## Timing
- An event sampled on cycle T produces `flush` and the CP0 pulses on T+1 only. `redirect_valid` rises on T+1.
- Earliest return to IDLE is T+2; a new event can be sampled on T+2.
- Interrupt latency from `int_raw` to eligibility: 2 cycles for level lines, 3 cycles for edge lines.
- Reset asynchronously forces IDLE and clears synchronisers, sticky bits and holding registers. Every output reads 0 during and after reset.
  - A reset during WAIT_RDY drops `redirect_valid` immediately.

## Configuration
- `EXCEPTION_CTRL_VECTORED_INT_EN` defined: an interrupt with `special_int_vec` targets base + 0x200 + index × `VEC_SPACING`.
- Undefined: every interrupt with `special_int_vec` targets base+0x200. The index encoder is not built.

## Structure
- Shared package `exception_pkg`: state encoding (IDLE/FLUSH/WAIT_RDY), cause-code constants (Int 0x00, Mod 0x01, TLBL 0x02, TLBS 0x03, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0a, CpU 0x0b, Ov 0x0c), vector offsets 0x000/0x180/0x200, boot base 32'hBFC00200.
- One sub-module, `int_line_sync`: per-line synchroniser plus edge/level latch, instantiated `NUM_INT` times.

## Test plan
- Edge on line 3, mask 0x08, `allow_int`=1, ebase 0x80000, vectored build, `special_int_vec`=1 -> `redirect_pc`=0x80000260, `exp_code`=0, `flush` exactly 1 cycle.
- `exc_valid` code 0x0c with `pc_value`=0x80001004 and `in_delayslot`=1 -> `exp_epc`=0x80001000, `redirect_pc`=base+0x180.
- `exc_tlb_refill` with `exl_in`=0, then with `exl_in`=1 -> `redirect_pc` base+0x000, then base+0x180. `cp0_exp_asid_we`=1 with the captured ASID in both cases.
- `eret` with `epc_in`=0x80002000 and `redirect_ready` held low 4 cycles -> `cp0_clean_exl` pulse, `redirect_valid` held 5 cycles with a stable PC. A second `eret` during WAIT_RDY is ignored.
- Interrupt and `exc_valid` on the same cycle -> interrupt taken. `int_clear` and a new edge on the same cycle -> line stays pending.
- `rst_n` low during WAIT_RDY -> all outputs 0 immediately; `int_pending`=0 after release.
